// File: rtl/edge_pkg.sv
// Shared definitions for the edge detector memory controllers.
package edge_pkg;

  // Default image geometry, shared with the read-side controller.
  localparam int IMG_W = 512;
  localparam int IMG_H = 512;

  // Write-side controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RIGHT = 2'd1,
    ST_LEFT  = 2'd2,
    ST_FLUSH = 2'd3
  } wr_state_t;

endpackage

// File: rtl/serp_counter.sv
// Serpentine scan position: x, y, accumulated row base and scan direction.
// Even rows run left-to-right, odd rows right-to-left; x is held across
// the turn so the next row starts at the same column it ended on.
module serp_counter
  import edge_pkg::*;
#(
  parameter int IMG_W = edge_pkg::IMG_W,
  parameter int IMG_H = edge_pkg::IMG_H,
  parameter int RB_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     step,
  output logic [$clog2(IMG_W)-1:0] x,
  output logic [RB_W-1:0]          row_base,
  output logic                     last_in_row,
  output logic                     last_in_frame
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H + 1);

  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [RB_W-1:0] row_base_q, row_base_d;
  logic            dir_left_q, dir_left_d;

  assign x             = x_q;
  assign row_base      = row_base_q;
  assign last_in_row   = dir_left_q ? (x_q == {XW{1'b0}}) : (x_q == XW'(IMG_W - 1));
  assign last_in_frame = last_in_row && dir_left_q && (y_q == YW'(IMG_H - 1));

  // Next position: clear on a new frame, advance on each accepted pixel.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    dir_left_d = dir_left_q;
    if (clear) begin
      x_d        = {XW{1'b0}};
      y_d        = {YW{1'b0}};
      row_base_d = {RB_W{1'b0}};
      dir_left_d = 1'b0;
    end else if (step) begin
      if (last_in_row) begin
        y_d        = y_q + YW'(1);
        row_base_d = row_base_q + RB_W'(IMG_W);
        dir_left_d = ~dir_left_q;
      end else if (dir_left_q) begin
        x_d = x_q - XW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end else begin
      x_d = x_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= {XW{1'b0}};
      y_q        <= {YW{1'b0}};
      row_base_q <= {RB_W{1'b0}};
      dir_left_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      dir_left_q <= dir_left_d;
    end
  end

endmodule

// File: rtl/mem_writer.sv
// Write-side memory controller: takes serpentine-ordered edge pixels and
// issues one registered row-major SRAM write per pixel under back-pressure.
module mem_writer
  import edge_pkg::*;
#(
  parameter int IMG_W     = edge_pkg::IMG_W,
  parameter int IMG_H     = edge_pkg::IMG_H,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              mem_busy,
  output logic              write_enable,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              row_done,
  output logic              frame_done,
  output logic              busy
);

  localparam int XW = $clog2(IMG_W);

  wr_state_t         state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              row_done_q, row_done_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;

  logic              scanning_s;
  logic              accept_s;
  logic              complete_s;
  logic              ctr_clear_s;
  logic [XW-1:0]     x_s;
  logic [ADDR_W-1:0] row_base_s;
  logic [ADDR_W-1:0] addr_s;
  logic              last_in_row_s;
  logic              last_in_frame_s;

  serp_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .RB_W  (ADDR_W)
  ) u_serp (
    .clk           (clk),
    .rst           (rst),
    .clear         (ctr_clear_s),
    .step          (accept_s),
    .x             (x_s),
    .row_base      (row_base_s),
    .last_in_row   (last_in_row_s),
    .last_in_frame (last_in_frame_s)
  );

  // A new pixel may enter whenever the write register is empty or draining.
  assign scanning_s = (state_q == ST_RIGHT) || (state_q == ST_LEFT);
  assign in_ready   = scanning_s && (!we_q || !mem_busy);
  assign accept_s   = in_valid && in_ready;
  assign complete_s = we_q && !mem_busy;
  assign addr_s     = ADDR_W'(BASE_ADDR) + row_base_s + ADDR_W'(x_s);

  assign write_enable = we_q;
  assign wr_addr      = addr_q;
  assign wr_data      = data_q;
  assign row_done     = row_done_q;
  assign frame_done   = frame_done_q;
  assign busy         = busy_q;

  // Next-state, write register and status pulses.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    data_d       = data_q;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    ctr_clear_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RIGHT;
          busy_d      = 1'b1;
          ctr_clear_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RIGHT: begin
        if (accept_s && last_in_row_s) begin
          state_d = ST_LEFT;
        end else begin
          state_d = ST_RIGHT;
        end
      end
      ST_LEFT: begin
        if (accept_s && last_in_row_s) begin
          state_d = last_in_frame_s ? ST_FLUSH : ST_RIGHT;
        end else begin
          state_d = ST_LEFT;
        end
      end
      ST_FLUSH: begin
        if (complete_s) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (accept_s) begin
      we_d       = 1'b1;
      addr_d     = addr_s;
      data_d     = in_data;
      row_done_d = last_in_row_s;
    end else if (complete_s) begin
      we_d = 1'b0;
    end else begin
      we_d = we_q;
    end
  end

  // Controller state and registered outputs; reset drops any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      data_q       <= {DATA_W{1'b0}};
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_writer.sv
// Directed self-checking bench for mem_writer on an 8x4 image; a second
// instance with BASE_ADDR=1000 shares all inputs to check the offset.
module tb_mem_writer;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int BASE1 = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = 8'd0;
  logic          mem_busy = 1'b0;

  logic          a_in_ready, a_write_enable, a_row_done, a_frame_done, a_busy;
  logic [AW-1:0] a_wr_addr;
  logic [DW-1:0] a_wr_data;
  logic          b_in_ready, b_write_enable, b_row_done, b_frame_done, b_busy;
  logic [AW-1:0] b_wr_addr;
  logic [DW-1:0] b_wr_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .mem_busy(mem_busy), .write_enable(a_write_enable),
    .wr_addr(a_wr_addr), .wr_data(a_wr_data), .row_done(a_row_done),
    .frame_done(a_frame_done), .busy(a_busy)
  );

  mem_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .mem_busy(mem_busy), .write_enable(b_write_enable),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .row_done(b_row_done),
    .frame_done(b_frame_done), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Row-major address of the k-th pixel in serpentine order.
  function automatic int exp_addr(input int k);
    int yy;
    int ii;
    yy = k / W;
    ii = k % W;
    return yy * W + (((yy % 2) == 0) ? ii : (W - 1 - ii));
  endfunction

  function automatic logic [7:0] pix(input int k);
    return 8'((k * 7 + 3) & 255);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},   32'(a_write_enable), 32'd0);
    check({tag, "_addr"}, 32'(a_wr_addr),      32'd0);
    check({tag, "_data"}, 32'(a_wr_data),      32'd0);
    check({tag, "_rdy"},  32'(a_in_ready),     32'd0);
    check({tag, "_rowd"}, 32'(a_row_done),     32'd0);
    check({tag, "_frmd"}, 32'(a_frame_done),   32'd0);
    check({tag, "_busy"}, 32'(a_busy),         32'd0);
    check({tag, "_b_we"}, 32'(b_write_enable), 32'd0);
    check({tag, "_b_ad"}, 32'(b_wr_addr),      32'd0);
  endtask

  // One frame: rnd toggles in_valid, stall_k stalls that pixel's write for
  // 3 cycles, restart_at pulses start mid-frame, abort_k resets at that write.
  task automatic run_frame(input bit rnd, input int stall_k, input int restart_at,
                           input int abort_k, input bit check_len);
    int acc;
    int wr;
    int rows;
    int edges;
    int last_acc;
    int stall_left;
    int fd_edge;
    bit done;
    acc = 0; wr = 0; rows = 0; edges = 0; last_acc = -100; stall_left = 3;
    fd_edge = -1; done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mem_busy = 1'b0; in_valid = 1'b1; in_data = pix(0);
    while (!done && edges < 300) begin
      @(posedge clk); #1;
      edges++;
      if (abort_k >= 0 && a_write_enable && (32'(a_wr_addr) == 32'(exp_addr(abort_k)))) begin
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        return;
      end
      start = (restart_at >= 0 && acc == restart_at) ? 1'b1 : 1'b0;
      if (a_row_done) rows++;
      if (a_write_enable) check("we_after_accept", 32'(acc > wr), 32'd1);
      if (a_frame_done) begin
        fd_edge = edges;
        done = 1'b1;
        check("busy_at_frame_done", 32'(a_busy), 32'd0);
        check("frame_done_latency", 32'(edges - last_acc), 32'd2);
      end else begin
        check("busy_in_frame", 32'(a_busy), 32'd1);
      end
      mem_busy = (stall_k >= 0 && a_write_enable && stall_left > 0 &&
                  32'(a_wr_addr) == 32'(exp_addr(stall_k))) ? 1'b1 : 1'b0;
      if (mem_busy) begin
        stall_left--;
        check("stall_addr", 32'(a_wr_addr), 32'(exp_addr(stall_k)));
        check("stall_data", 32'(a_wr_data), 32'(pix(stall_k)));
      end
      if (acc < W * H) begin
        in_valid = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      in_data = pix(acc);
      #1;
      if (edges == 1) check("start_latency_ready", 32'(a_in_ready), 32'd1);
      if (mem_busy) check("stall_ready", 32'(a_in_ready), 32'd0);
      if (a_write_enable && !mem_busy) begin
        check("wr_addr", 32'(a_wr_addr), 32'(exp_addr(wr)));
        check("wr_addr_base", 32'(b_wr_addr), 32'(exp_addr(wr) + BASE1));
        check("wr_data", 32'(a_wr_data), 32'(pix(wr)));
        wr++;
      end
      if (in_valid && a_in_ready) begin
        acc++;
        last_acc = edges;
      end
    end
    in_valid = 1'b0; mem_busy = 1'b0; start = 1'b0;
    check("frame_done_seen", 32'(fd_edge >= 0), 32'd1);
    check("write_count", 32'(wr), 32'(W * H));
    check("row_done_count", 32'(rows), 32'(H));
    if (check_len) check("frame_length", 32'(fd_edge), 32'(W * H + 2));
    @(posedge clk); #1;
    check("frame_done_pulse", 32'(a_frame_done), 32'd0);
    check("idle_after_frame", 32'(a_in_ready), 32'd0);
  endtask

  initial begin
    // Reset state.
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // in_valid before start is ignored.
    in_valid = 1'b1;
    in_data = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("idle_ready", 32'(a_in_ready), 32'd0);
      check("idle_we", 32'(a_write_enable), 32'd0);
    end
    in_valid = 1'b0;

    // Full frame, no stalls, checked frame length.
    run_frame(1'b0, -1, -1, -1, 1'b1);
    // Back-pressure on the write to address 5.
    run_frame(1'b0, 5, -1, -1, 1'b0);
    // Random input bubbles plus a start pulse mid-frame.
    run_frame(1'b1, -1, 10, -1, 1'b0);

    // Reset at pixel (3,2), then verify nothing more is written.
    run_frame(1'b0, -1, -1, 19, 1'b0);
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("post_reset_we", 32'(a_write_enable), 32'd0);
      check("post_reset_fd", 32'(a_frame_done), 32'd0);
    end
    in_valid = 1'b0;

    // A fresh frame after the reset starts again at the base address.
    run_frame(1'b0, -1, -1, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_writer.md
# mem_writer

Write-side memory controller for the edge detector. It accepts final edge pixels from the hysteresis stage in the same serpentine order the read-side controller scans them: even rows left-to-right, odd rows right-to-left. It converts each pixel to a row-major linear address in the output SRAM and issues one registered write per pixel, honouring memory back-pressure. It reports row and frame completion to the top-level sequencer.

## Interface
Parameters:
- IMG_W, 512, output image width in pixels; must be a power of 2.
- IMG_H, 512, output image height in rows; must be even.
- ADDR_W, 19, SRAM address width.
- DATA_W, 8, pixel width.
- BASE_ADDR, 0, address of output pixel (0,0).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that arms a new frame.
- in_valid  in  1  pixel present on in_data.
- in_data  in  DATA_W  edge pixel value.
- in_ready  out  1  writer can accept a pixel this cycle.
- mem_busy  in  1  SRAM cannot take a write this cycle.
- write_enable  out  1  write request to SRAM.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- row_done  out  1  one-cycle pulse when the last pixel of a row is accepted.
- frame_done  out  1  one-cycle pulse when the final write completes.
- busy  out  1  high from start until frame_done.

## Operation
- **States:** IDLE, RIGHT, LEFT, FLUSH.
- **IDLE:**
  - start goes to RIGHT with x=0, y=0, row_base=0.
  - in_valid is ignored and in_ready is 0.
- **Accept:** a pixel is accepted when in_valid && in_ready.
- **RIGHT (even rows):**
  - Each accept increments x.
  - An accept at x=IMG_W-1 pulses row_done, increments y, adds IMG_W to row_base, holds x, and goes to LEFT.
- **LEFT (odd rows):**
  - Each accept decrements x.
  - An accept at x=0 pulses row_done, increments y, adds IMG_W to row_base, and goes to RIGHT.
  - If that row is y=IMG_H-1, the state goes to FLUSH instead.
- **Address:** wr_addr = BASE_ADDR + row_base + x, truncated to ADDR_W.
  - It is computed from the x and row_base values before the accept updates them.
  - No multiplier is used; row_base is accumulated.
- **Write register:**
  - On accept, wr_addr, wr_data and write_enable=1 are loaded.
  - A write completes on any cycle with write_enable && !mem_busy.
  - On completion with no new accept, write_enable clears.
- **in_ready:** in_ready = (state is RIGHT or LEFT) && (!write_enable || !mem_busy).
  - An accept and a completion in the same cycle are legal, giving 1 pixel/cycle throughput.
- **FLUSH:** once the pending write completes, frame_done pulses and the state returns to IDLE.
- **Ignored start:** start outside IDLE has no effect.

## Timing
- **Reset values:** all outputs 0; state IDLE; x, y and row_base 0. A pending write is dropped.
- **Reset mid-frame:** acts immediately (asynchronous). No further writes are issued and no frame_done pulse occurs.
- **Start latency:** start in cycle N gives in_ready=1 and busy=1 in cycle N+1.
- **Accept latency:** an accept in cycle N puts the write on the SRAM port in cycle N+1.
- **Back-pressure:** while mem_busy=1, wr_addr, wr_data and write_enable=1 stay stable, and in_ready=0.
- **row_done:** registered pulse in the cycle after the accept of the row's last pixel.
- **frame_done:** pulse in the cycle after the final write completes. busy drops in that same cycle. The earliest end is 2 cycles after the final accept.
- **Frame length:** with no stalls, an IMG_W×IMG_H frame takes IMG_W*IMG_H+2 cycles from start to frame_done.

## Structure
- **Shared package edge_pkg:**
  - wr_state_t enum for IDLE, RIGHT, LEFT and FLUSH.
  - Default image constants IMG_W and IMG_H, which the read controller also uses.
- **Sub-module serp_counter:** holds the x/y/row_base registers plus direction.
  - Outputs last_in_row and last_in_frame.
  - The mem_writer FSM and write register instantiate it.

## Test plan
- **Full frame, no stalls:** IMG_W=8, IMG_H=4, in_valid constantly 1, mem_busy=0 → addresses in order:
  - row 0: 0..7
  - row 1: 15..8
  - row 2: 16..23
  - row 3: 31..24
  - Expect 4 row_done pulses, frame_done 2 cycles after the last accept, and 34 cycles from start.
- **Back-pressure:** hold mem_busy=1 for 3 cycles during the write to address 5 → wr_addr=5 and wr_data stay stable, in_ready=0 for those 3 cycles, with no lost or duplicated write.
- **Input bubbles:** toggle in_valid randomly → the address sequence is identical to the first scenario and write_enable is high only after accepts.
- **Idle input:** in_valid=1 before start → in_ready=0 and no writes. A start pulse while busy does not reset x or y.
- **Mid-frame reset:** assert rst asynchronously at pixel (3,2) → all outputs go to 0 immediately. A new start begins again at address BASE_ADDR.
- **BASE_ADDR offset:** BASE_ADDR=1000 → the first write goes to 1000 and the last write (x=0, y=IMG_H-1) goes to 1000+(IMG_H-1)*IMG_W.
